tradeoff_sched: RTL and testbench

Round-robin scheduler that shares one `Tradeoff_8bits` search engine among `NREQ` requesters. It accepts a `W` operand from one requester at a time and pulses the engine start. It then waits for `found` or a timeout and returns `N` with the requester ID over a valid/ready response port. It sits between the host-side request ports and the single engine instance, and is the only block driving the engine's `W` input.

---
 rtl/tradeoff_sched.sv | 136 +++++++++++++
 tb/tb_tradeoff_sched.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/tradeoff_sched.sv
// Round-robin front end that shares one Tradeoff_8bits search engine among NREQ requesters,
// issuing one operand at a time and returning the result (or a timeout abort) with its owner ID.
module tradeoff_sched #(
  parameter int NREQ    = 4,
  parameter int W_BITS  = 20,
  parameter int N_BITS  = 9,
  parameter int TIMEOUT = 1023,
  localparam int ID_W   = $clog2(NREQ),
  localparam int CNT_W  = $clog2(TIMEOUT + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*W_BITS-1:0]   req_w,
  output logic [NREQ-1:0]          req_ready,
  output logic [W_BITS-1:0]        eng_w,
  output logic                     eng_start,
  input  logic                     eng_found,
  input  logic [N_BITS-1:0]        eng_n,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [N_BITS-1:0]        rsp_n,
  output logic                     rsp_timeout,
  output logic                     busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t              state_q;
  logic [ID_W-1:0]     last_q;
  logic [ID_W-1:0]     id_q;
  logic [W_BITS-1:0]   eng_w_q;
  logic                eng_start_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                rsp_valid_q;
  logic [N_BITS-1:0]   rsp_n_q;
  logic                rsp_timeout_q;

  logic                grant_vld_d;
  logic [ID_W-1:0]     grant_d;
  logic [ID_W-1:0]     cand_d;
  logic [W_BITS-1:0]   sel_w_d;
  logic [CNT_W-1:0]    cnt_d;
  logic                timeout_hit;

  // Search starts just after the last served requester so every active requester gets a turn.
  always_comb begin
    grant_vld_d = 1'b0;
    grant_d     = '0;
    cand_d      = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand_d = ID_W'((int'(last_q) + i) % NREQ);
      if (!grant_vld_d && req_valid[cand_d]) begin
        grant_vld_d = 1'b1;
        grant_d     = cand_d;
      end
    end
  end

  always_comb begin
    sel_w_d   = '0;
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_d == ID_W'(i)) begin
        sel_w_d = req_w[i*W_BITS +: W_BITS];
      end
      req_ready[i] = (state_q == IDLE) && grant_vld_d && (grant_d == ID_W'(i));
    end
  end

  assign cnt_d       = cnt_q + CNT_W'(1);
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  // A found level seen outside WAIT belongs to an older job, so only WAIT looks at eng_found.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      last_q        <= ID_W'(NREQ - 1);
      id_q          <= '0;
      eng_w_q       <= '0;
      eng_start_q   <= 1'b0;
      cnt_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_n_q       <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (grant_vld_d) begin
            eng_w_q     <= sel_w_d;
            id_q        <= grant_d;
            eng_start_q <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          eng_start_q <= 1'b0;
          cnt_q       <= '0;
          state_q     <= WAIT;
        end
        WAIT: begin
          cnt_q <= cnt_d;
          if (eng_found) begin
            rsp_n_q       <= eng_n;
            rsp_timeout_q <= 1'b0;
            rsp_valid_q   <= 1'b1;
            state_q       <= RESP;
          end else if (timeout_hit) begin
            rsp_n_q       <= '0;
            rsp_timeout_q <= 1'b1;
            rsp_valid_q   <= 1'b1;
            state_q       <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            last_q      <= id_q;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign eng_w       = eng_w_q;
  assign eng_start   = eng_start_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = id_q;
  assign rsp_n       = rsp_n_q;
  assign rsp_timeout = rsp_timeout_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_tradeoff_sched.sv
// Self-checking bench for tradeoff_sched: a table of jobs driven against a scripted engine stub,
// with expected responses queued on issue and compared when the response port presents them.
module tb_tradeoff_sched;

  localparam int NREQ    = 4;
  localparam int W_BITS  = 20;
  localparam int N_BITS  = 9;
  localparam int TIMEOUT = 16;

  logic                   clk;
  logic                   rst;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*W_BITS-1:0] req_w;
  logic [NREQ-1:0]        req_ready;
  logic [W_BITS-1:0]      eng_w;
  logic                   eng_start;
  logic                   eng_found;
  logic [N_BITS-1:0]      eng_n;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [1:0]             rsp_id;
  logic [N_BITS-1:0]      rsp_n;
  logic                   rsp_timeout;
  logic                   busy;

  typedef struct {
    logic [3:0]  mask;
    logic [1:0]  expId;
    logic [19:0] w;
    int          delay;
    logic [8:0]  n;
    int          hold;
    bit          stale;
    bit          expTo;
    logic [8:0]  expN;
    int          expLat;
  } vec_t;

  typedef struct {
    logic [1:0] id;
    logic [8:0] n;
    bit         to;
  } exp_t;

  exp_t sbQ[$];
  vec_t vecs[10];
  vec_t postReset;
  int   testsRun;
  int   testsFailed;

  tradeoff_sched #(
    .NREQ(NREQ), .W_BITS(W_BITS), .N_BITS(N_BITS), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_w(req_w), .req_ready(req_ready),
    .eng_w(eng_w), .eng_start(eng_start), .eng_found(eng_found), .eng_n(eng_n),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_n(rsp_n), .rsp_timeout(rsp_timeout), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    testsRun++;
    if (act !== expv) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Each requester gets a distinct operand; the one expected to win carries v.w exactly.
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    int   lat;
    for (int i = 0; i < NREQ; i++) begin
      req_w[i*W_BITS +: W_BITS] = v.w + 20'(i) - 20'(v.expId);
    end
    req_valid = v.mask;
    rsp_ready = 1'b0;
    eng_found = 1'b0;
    #1;
    checkOutput("req_ready_grant", 32'(req_ready), 32'(4'b0001 << v.expId));
    e.id = v.expId;
    e.n  = v.expN;
    e.to = v.expTo;
    sbQ.push_back(e);

    tick;
    checkOutput("eng_start_pulse", 32'(eng_start), 32'(1));
    checkOutput("eng_w_operand", 32'(eng_w), 32'(v.w));
    checkOutput("busy_issue", 32'(busy), 32'(1));
    checkOutput("req_ready_issue", 32'(req_ready), 32'(0));
    eng_found = v.stale;
    eng_n     = 9'h1AA;

    tick;
    checkOutput("eng_start_single", 32'(eng_start), 32'(0));
    lat = 0;
    while (!rsp_valid && lat < 64) begin
      eng_found = (v.delay >= 0) && (lat >= v.delay);
      eng_n     = v.n;
      tick;
      lat++;
    end
    checkOutput("rsp_latency", 32'(lat), 32'(v.expLat));
    checkOutput("eng_w_held", 32'(eng_w), 32'(v.w));

    if (sbQ.size() == 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL scoreboard: got 0 queued entries, expected 1");
    end else begin
      e = sbQ.pop_front();
      checkOutput("rsp_valid", 32'(rsp_valid), 32'(1));
      checkOutput("rsp_id", 32'(rsp_id), 32'(e.id));
      checkOutput("rsp_n", 32'(rsp_n), 32'(e.n));
      checkOutput("rsp_timeout", 32'(rsp_timeout), 32'(e.to));
      for (int h = 0; h < v.hold; h++) begin
        tick;
        checkOutput("hold_rsp_valid", 32'(rsp_valid), 32'(1));
        checkOutput("hold_rsp_id", 32'(rsp_id), 32'(e.id));
        checkOutput("hold_rsp_n", 32'(rsp_n), 32'(e.n));
        checkOutput("hold_req_ready", 32'(req_ready), 32'(0));
      end
    end

    rsp_ready = 1'b1;
    tick;
    checkOutput("rsp_valid_cleared", 32'(rsp_valid), 32'(0));
    checkOutput("busy_idle", 32'(busy), 32'(0));
    rsp_ready = 1'b0;
    req_valid = '0;
    eng_found = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 100000 ns");
    $fatal(1);
  end

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rst         = 1'b1;
    req_valid   = '0;
    req_w       = '0;
    eng_found   = 1'b0;
    eng_n       = '0;
    rsp_ready   = 1'b0;

    //         mask   id  w         dly n      hold stale to  expN   lat
    vecs[0] = '{4'hF, 2'd0, 20'h11111, 0, 9'h011, 0, 1'b1, 1'b0, 9'h011, 1};
    vecs[1] = '{4'hF, 2'd1, 20'h22222, 1, 9'h022, 0, 1'b0, 1'b0, 9'h022, 2};
    vecs[2] = '{4'hF, 2'd2, 20'h33333, 2, 9'h033, 0, 1'b1, 1'b0, 9'h033, 3};
    vecs[3] = '{4'hF, 2'd3, 20'h44444, 0, 9'h044, 0, 1'b0, 1'b0, 9'h044, 1};
    vecs[4] = '{4'hF, 2'd0, 20'h55555, 3, 9'h055, 0, 1'b0, 1'b0, 9'h055, 4};
    vecs[5] = '{4'hF, 2'd1, 20'h66666, 0, 9'h066, 0, 1'b0, 1'b0, 9'h066, 1};
    vecs[6] = '{4'h4, 2'd2, 20'd123456, 4, 9'd255, 0, 1'b0, 1'b0, 9'd255, 5};
    vecs[7] = '{4'h3, 2'd0, 20'h0ABCD, -1, 9'h1FF, 0, 1'b0, 1'b1, 9'h000, TIMEOUT};
    vecs[8] = '{4'hA, 2'd1, 20'h0F00F, 2, 9'h1A5, 10, 1'b0, 1'b0, 9'h1A5, 3};
    vecs[9] = '{4'h8, 2'd3, 20'hFFFFF, TIMEOUT-1, 9'h1C3, 0, 1'b0, 1'b0, 9'h1C3, TIMEOUT};
    postReset = '{4'h6, 2'd1, 20'h5A5A5, 2, 9'h099, 0, 1'b1, 1'b0, 9'h099, 3};

    @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 32'(0));
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'(0));
    checkOutput("reset_eng_start", 32'(eng_start), 32'(0));
    checkOutput("reset_eng_w", 32'(eng_w), 32'(0));
    checkOutput("reset_req_ready", 32'(req_ready), 32'(0));
    rst = 1'b0;
    tick;

    for (int c = 0; c < 3; c++) begin
      tick;
      checkOutput("idle_no_req_ready", 32'(req_ready), 32'(0));
      checkOutput("idle_no_req_busy", 32'(busy), 32'(0));
    end

    for (int k = 0; k < 10; k++) begin
      applyStimulus(vecs[k]);
    end

    // Abort a job mid-WAIT; the reset must clear every output without waiting for a clock edge.
    req_w     = '0;
    req_w[W_BITS-1:0] = 20'h12345;
    req_valid = 4'b0001;
    #1;
    checkOutput("pre_reset_grant", 32'(req_ready), 32'(4'b0001));
    tick;
    checkOutput("pre_reset_busy", 32'(busy), 32'(1));
    tick;
    tick;
    req_valid = '0;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_busy", 32'(busy), 32'(0));
    checkOutput("async_eng_w", 32'(eng_w), 32'(0));
    checkOutput("async_eng_start", 32'(eng_start), 32'(0));
    checkOutput("async_rsp_valid", 32'(rsp_valid), 32'(0));
    checkOutput("async_rsp_id", 32'(rsp_id), 32'(0));
    checkOutput("async_rsp_n", 32'(rsp_n), 32'(0));
    checkOutput("async_rsp_timeout", 32'(rsp_timeout), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    tick;
    applyStimulus(postReset);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
